// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port clearable RAM.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package ram_pkg;

    // Clear-engine FSM encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Legal read latency window; 2 adds an output register after the array read
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array: one write port, one registered read port with optional write-first forwarding.
// Latency: 1 cycle from i_re to data_rd.
// Backpressure: none; every enabled access completes on its edge.
//
// Ports: i_clk/i_rst_n; write port (we, addr_wr, data_wr); read port (re, addr_rd) -> data_rd.
// data_rd only changes on an enabled read, so it holds between reads.
module ram_sdp_core #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RDW_FWD    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [WIDTH-1:0]      data_wr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [WIDTH-1:0]      data_rd
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // No reset on the array so it maps onto block RAM
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[addr_wr] <= data_wr;
        end
    end

    // Same-address collision: the array read sees pre-write contents (old data);
    // forwarding substitutes the incoming word when new data is wanted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_rd <= '0;
        end else if (re) begin
            if ((RDW_FWD != 0) && we && (addr_wr == addr_rd)) begin
                data_rd <= data_wr;
            end else begin
                data_rd <= mem[addr_rd];
            end
        end
    end

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with a hardware clear engine that zeroes the array after reset or on i_clr.
// Latency: RD_LATENCY (1 or 2) cycles from accepted i_re to o_valid/o_data; full throughput.
// Backpressure: none on reads/writes; all requests (including i_clr) are dropped while o_busy = 1.
//
// Ports: i_clk, i_rst_n (async, active low); i_clr -> o_busy (clear sweep);
// write: i_we, i_addr_wr, i_data; read: i_re, i_addr_rd -> o_data, o_valid.
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int RD_LATENCY   = 1,
    parameter int RDW_FWD      = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    output logic                  o_busy,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr_wr,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr_rd,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid
);

    if (!rd_lat_legal(RD_LATENCY)) begin : g_bad_rd_latency
        $error("ram_sdp_clr: RD_LATENCY must be 1 or 2");
    end

    localparam state_t                ST_RST  = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy;

    // ---------------- clear FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_clr) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // counter wraps to 0 on the last word, ready for the next sweep
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy   = (state_q == ST_CLEAR);
    assign o_busy = busy;

    // ---------------- write mux: sweep owns the write port while busy ----------------
    logic                  user_we, user_re;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr_wr;
    logic [WIDTH-1:0]      core_data_wr;
    logic [WIDTH-1:0]      core_q;

    assign user_we      = i_we & ~busy;
    assign user_re      = i_re & ~busy;
    assign core_we      = busy | user_we;
    assign core_addr_wr = busy ? cnt_q : i_addr_wr;
    assign core_data_wr = busy ? '0    : i_data;

    ram_sdp_core #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RDW_FWD    (RDW_FWD)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .we      (core_we),
        .addr_wr (core_addr_wr),
        .data_wr (core_data_wr),
        .re      (user_re),
        .addr_rd (i_addr_rd),
        .data_rd (core_q)
    );

    // ---------------- read valid / latency pipeline ----------------
    // Valid tracks accepted reads only, so results in flight when a sweep
    // starts still emerge, and no strobes are produced during the sweep.
    logic rd_vld1_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld1_q <= 1'b0;
        end else begin
            rd_vld1_q <= user_re;
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign o_data  = core_q;
        assign o_valid = rd_vld1_q;
    end else begin : g_lat2
        logic             rd_vld2_q;
        logic [WIDTH-1:0] rd_dat2_q;

        // Output register loads only with a valid word so o_data holds otherwise
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_vld2_q <= 1'b0;
                rd_dat2_q <= '0;
            end else begin
                rd_vld2_q <= rd_vld1_q;
                if (rd_vld1_q) begin
                    rd_dat2_q <= core_q;
                end
            end
        end

        assign o_data  = rd_dat2_q;
        assign o_valid = rd_vld2_q;
    end

endmodule
